data_bus_responder: RTL and testbench

- Memory-side responder for the core's data-bus load/store initiator.
- Accepts one byte, half or word request at a time and inserts configurable wait states.
- Performs little-endian, byte-lane-masked writes and sign- or zero-extended reads.
- Signals completion through `ready` and flags illegal or misaligned accesses with a one-cycle `err` pulse.
- Sits between the core's bus control and on-chip data RAM; the core stalls its PC while `ready` is low.

---
 rtl/data_bus_responder.sv | 204 ++++++++++++++++++++
 tb/tb_data_bus_responder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// Data-RAM responder for the core's load/store port: byte/half/word, little-endian, sign/zero-extended loads.
// Latency: request sampled at edge T completes at edge T+WAIT_STATES+1; data_out/err valid the cycle after.
// Backpressure: ready=0 while busy; request inputs are ignored until ready returns to 1.
module data_bus_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wd,
  input  logic                  rd,
  input  logic [1:0]            size,
  input  logic                  unsigned_value,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready,
  output logic                  err
);

  localparam int             WORD_AW      = ADDR_WIDTH - 2;
  localparam int             DEPTH        = 1 << WORD_AW;
  localparam logic [3:0]     WAIT_CNT_MAX = 4'(WAIT_STATES);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // Request captured at acceptance; everything after IDLE works from this copy.
  typedef struct packed {
    logic                  is_write;
    logic [1:0]            size;
    logic                  uns;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdat;
  } req_t;

  state_t               state_q, state_d;
  req_t                 req_q;
  logic                 accept;
  logic [3:0]           wait_cnt;
  logic [3:0]           cnt_inc;
  logic                 legal;
  logic                 do_access;
  logic [WORD_AW-1:0]   widx;
  logic [3:0]           lane_en;
  logic [31:0]          wr_lanes;
  logic [31:0]          rd_word;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [31:0]          rd_ext;

  logic [31:0]          mem [DEPTH];

  assign cnt_inc   = wait_cnt + 4'd1;
  assign widx      = req_q.addr[ADDR_WIDTH-1:2];
  assign rd_word   = mem[widx];
  assign ready     = (state_q == ST_IDLE);
  // A reset landing on the ACCESS edge aborts the transaction, so it also blocks the RAM write.
  assign do_access = (state_q == ST_ACCESS) && !rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a request is only accepted in IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd || wd) begin
          accept  = 1'b1;
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (cnt_inc == WAIT_CNT_MAX) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Wait-state counter: runs 1..WAIT_STATES while in WAIT, parked at 0 otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if (state_q == ST_WAIT) begin
      wait_cnt <= cnt_inc;
    end else begin
      wait_cnt <= 4'd0;
    end
  end

  // Request capture; write wins when rd and wd arrive together. Datapath only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_q.is_write <= wd;
      req_q.size     <= size;
      req_q.uns      <= unsigned_value;
      req_q.addr     <= addr;
      req_q.wdat     <= data_in[31:0];
    end
  end

  // Alignment check: bytes anywhere, halves on even addresses, words on 4-byte boundaries.
  always_comb begin
    legal = 1'b0;
    case (req_q.size)
      SZ_BYTE: legal = 1'b1;
      SZ_HALF: legal = (req_q.addr[0] == 1'b0);
      SZ_WORD: legal = (req_q.addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Store lane enables, with the right-aligned store data replicated into every candidate lane.
  always_comb begin
    lane_en  = 4'b0000;
    wr_lanes = req_q.wdat;
    case (req_q.size)
      SZ_BYTE: begin
        lane_en  = 4'b0001 << req_q.addr[1:0];
        wr_lanes = {4{req_q.wdat[7:0]}};
      end
      SZ_HALF: begin
        lane_en  = req_q.addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{req_q.wdat[15:0]}};
      end
      SZ_WORD: begin
        lane_en  = 4'b1111;
        wr_lanes = req_q.wdat;
      end
      default: begin
        lane_en  = 4'b0000;
        wr_lanes = req_q.wdat;
      end
    endcase
  end

  // Load lane selection and sign/zero extension.
  always_comb begin
    byte_sel = rd_word[7:0];
    case (req_q.addr[1:0])
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = req_q.addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_q.size)
      SZ_BYTE: rd_ext = {{24{~req_q.uns & byte_sel[7]}}, byte_sel};
      SZ_HALF: rd_ext = {{16{~req_q.uns & half_sel[15]}}, half_sel};
      default: rd_ext = rd_word;
    endcase
  end

  // RAM store, byte-lane masked; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_access && req_q.is_write && legal) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          mem[widx][8*i +: 8] <= wr_lanes[8*i +: 8];
        end
      end
    end
  end

  // Response registers: load result held until the next load, err pulses for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state_q == ST_ACCESS) begin
        err <= ~legal;
        if (!req_q.is_write) begin
          data_out <= legal ? DATA_WIDTH'(rd_ext) : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: three instances with WAIT_STATES 1, 0 and 3.
// Checks load/store data, extension, lane masking, err pulses, ready-low duration and reset abort.
// Inputs driven on the falling edge; outputs sampled on the falling edge.
module tb_data_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  wd_v;
  logic [2:0]  rd_v;
  logic [1:0]  size_s;
  logic        uns_s;
  logic [11:0] addr_s;
  logic [31:0] din_s;
  logic [31:0] dout [3];
  logic [2:0]  rdy;
  logic [2:0]  er;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_bus_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .wd(wd_v[0]), .rd(rd_v[0]), .size(size_s),
    .unsigned_value(uns_s), .addr(addr_s), .data_in(din_s),
    .data_out(dout[0]), .ready(rdy[0]), .err(er[0])
  );

  data_bus_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .wd(wd_v[1]), .rd(rd_v[1]), .size(size_s),
    .unsigned_value(uns_s), .addr(addr_s), .data_in(din_s),
    .data_out(dout[1]), .ready(rdy[1]), .err(er[1])
  );

  data_bus_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .wd(wd_v[2]), .rd(rd_v[2]), .size(size_s),
    .unsigned_value(uns_s), .addr(addr_s), .data_in(din_s),
    .data_out(dout[2]), .ready(rdy[2]), .err(er[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction on instance idx, called on a falling edge with that instance idle.
  task automatic op(input int idx, input logic w, input logic r, input logic [1:0] sz,
                    input logic uns, input logic [11:0] a, input logic [31:0] d,
                    input int exp_lat, input logic exp_err, input logic [31:0] exp_do,
                    input string tag);
    int   lat;
    logic busy_err;
    lat      = 0;
    busy_err = 1'b0;
    wd_v[idx] = w;
    rd_v[idx] = r;
    size_s    = sz;
    uns_s     = uns;
    addr_s    = a;
    din_s     = d;
    @(posedge clk);
    #1;
    wd_v[idx] = 1'b0;
    rd_v[idx] = 1'b0;
    @(negedge clk);
    while (!rdy[idx] && lat < 40) begin
      lat++;
      if (er[idx]) busy_err = 1'b1;
      @(negedge clk);
    end
    chk({tag, "_lat"},      32'(lat), 32'(exp_lat));
    chk({tag, "_busy_err"}, {31'd0, busy_err}, 32'd0);
    chk({tag, "_err"},      {31'd0, er[idx]}, {31'd0, exp_err});
    chk({tag, "_data"},     dout[idx], exp_do);
    if (exp_err) begin
      @(negedge clk);
      chk({tag, "_err_end"}, {31'd0, er[idx]}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    wd_v   = 3'b000;
    rd_v   = 3'b000;
    size_s = 2'b00;
    uns_s  = 1'b0;
    addr_s = 12'h000;
    din_s  = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready",    {29'd0, rdy}, 32'h7);
    chk("rst_err",      {29'd0, er},  32'h0);
    chk("rst_data_ws1", dout[0], 32'h0);

    // WAIT_STATES=1: word store/load, extension, lane masking, back-to-back.
    op(0, 1, 0, 2'b10, 0, 12'h010, 32'h8899AABB, 2, 0, 32'h00000000, "sw_010");
    op(0, 0, 1, 2'b10, 0, 12'h010, 32'h0,        2, 0, 32'h8899AABB, "lw_010");
    op(0, 0, 1, 2'b00, 0, 12'h011, 32'h0,        2, 0, 32'hFFFFFFAA, "lb_011");
    op(0, 0, 1, 2'b00, 1, 12'h011, 32'h0,        2, 0, 32'h000000AA, "lbu_011");
    op(0, 0, 1, 2'b01, 0, 12'h012, 32'h0,        2, 0, 32'hFFFF8899, "lh_012");
    op(0, 0, 1, 2'b01, 1, 12'h012, 32'h0,        2, 0, 32'h00008899, "lhu_012");
    op(0, 1, 0, 2'b00, 0, 12'h013, 32'h0000005A, 2, 0, 32'h00008899, "sb_013");
    op(0, 0, 1, 2'b10, 0, 12'h010, 32'h0,        2, 0, 32'h5A99AABB, "lw_after_sb");
    op(0, 1, 0, 2'b01, 0, 12'h010, 32'hABCD1234, 2, 0, 32'h5A99AABB, "sh_010");
    op(0, 0, 1, 2'b10, 0, 12'h010, 32'h0,        2, 0, 32'h5A991234, "lw_after_sh");

    // Misaligned and illegal accesses.
    op(0, 1, 0, 2'b01, 0, 12'h011, 32'h0000FFFF, 2, 1, 32'h5A991234, "sh_011_mis");
    op(0, 0, 1, 2'b11, 0, 12'h010, 32'h0,        2, 1, 32'h00000000, "ld_size11");
    op(0, 0, 1, 2'b10, 0, 12'h010, 32'h0,        2, 0, 32'h5A991234, "lw_after_bad_sh");
    op(0, 0, 1, 2'b10, 0, 12'h006, 32'h0,        2, 1, 32'h00000000, "lw_006_mis");
    op(0, 0, 1, 2'b10, 0, 12'h010, 32'h0,        2, 0, 32'h5A991234, "lw_010_again");

    // rd and wd together: store wins, load dropped so data_out holds.
    op(0, 1, 1, 2'b10, 0, 12'h020, 32'hCAFEF00D, 2, 0, 32'h5A991234, "rdwd_020");
    op(0, 0, 1, 2'b10, 0, 12'h020, 32'h0,        2, 0, 32'hCAFEF00D, "lw_020");

    // WAIT_STATES=0: single-cycle busy.
    op(1, 1, 0, 2'b10, 0, 12'h040, 32'h01020304, 1, 0, 32'h00000000, "ws0_sw_040");
    op(1, 0, 1, 2'b10, 0, 12'h040, 32'h0,        1, 0, 32'h01020304, "ws0_lw_040");
    op(1, 0, 1, 2'b01, 0, 12'h042, 32'h0,        1, 0, 32'h00000102, "ws0_lh_042");
    op(1, 0, 1, 2'b00, 0, 12'h043, 32'h0,        1, 0, 32'h00000001, "ws0_lb_043");

    // WAIT_STATES=3: four-cycle busy.
    op(2, 1, 0, 2'b10, 0, 12'h030, 32'h11223344, 4, 0, 32'h00000000, "ws3_sw_030");
    op(2, 0, 1, 2'b10, 0, 12'h030, 32'h0,        4, 0, 32'h11223344, "ws3_lw_030");
    op(2, 0, 1, 2'b01, 0, 12'h030, 32'h0,        4, 0, 32'h00003344, "ws3_lh_030");

    // Reset on the second stall cycle aborts the store.
    wd_v[2] = 1'b1;
    size_s  = 2'b10;
    uns_s   = 1'b0;
    addr_s  = 12'h030;
    din_s   = 32'hDEADBEEF;
    @(posedge clk);
    #1 wd_v[2] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'd0, rdy[2]}, 32'd1);
    chk("abort_err",   {31'd0, er[2]},  32'd0);
    chk("abort_data",  dout[2], 32'h0);
    op(2, 0, 1, 2'b10, 0, 12'h030, 32'h0,        4, 0, 32'h11223344, "ws3_lw_after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
